uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 The block SHALL have parameter CLK_FREQ, default 50_000_000, system clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUD_RATE, default 115200, serial bit rate.
REQ-003 The block SHALL have parameter TX_BUFFER_DEPTH, default 32, TX FIFO depth in bytes (power of two, at least 2).
REQ-004 The block SHALL have port clk_50mhz, input, 1 bit, sole clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, synchronous active-low reset.
REQ-006 The block SHALL have port tx_data, input, 8 bits, byte to enqueue.
REQ-007 The block SHALL have port tx_valid, input, 1 bit, write strobe, sampled each cycle.
REQ-008 The block SHALL have port tx_out, output, 1 bit, serial line, idle high.
REQ-009 The block SHALL have port tx_busy, output, 1 bit, high while a frame is on the line.
REQ-010 The block SHALL have port buffer_full, output, 1 bit, FIFO holds TX_BUFFER_DEPTH bytes.
REQ-011 The block SHALL have port buffer_empty, output, 1 bit, FIFO holds 0 bytes.
REQ-012 The block SHALL have port overflow, output, 1 bit, one-cycle pulse when a write is dropped.

Function
REQ-013 The bit period SHALL be DIV = CLK_FREQ/BAUD_RATE clocks (integer division: 434 at defaults), and every bit SHALL hold for exactly DIV clocks.
REQ-014 The frame format SHALL be 8N1: start bit 0, data[0]..data[7] LSB first, stop bit 1, for 10*DIV clocks per frame.
REQ-015 A write SHALL be accepted on an edge where tx_valid=1 and buffer_full=0; tx_data SHALL be stored and the count incremented.
REQ-016 A write with buffer_full=1 SHALL be dropped, FIFO contents SHALL be unchanged, and overflow SHALL be 1 for exactly the next cycle.
REQ-017 buffer_full SHALL be evaluated before any same-cycle pop, so a write while full is dropped even if a pop occurs that cycle.
REQ-018 A simultaneous accepted write and pop when not full SHALL leave the count unchanged and preserve FIFO order.
REQ-019 FIFO read and write pointers SHALL wrap modulo TX_BUFFER_DEPTH, and the count SHALL range 0..TX_BUFFER_DEPTH.
REQ-020 The FSM SHALL have states IDLE, START, DATA, STOP, with a baud counter 0..DIV-1 and a bit index 0..7.
REQ-021 IDLE: tx_out=1, tx_busy=0; if buffer_empty=0, pop the head byte into the shift register and go to START.
REQ-022 START: tx_out=0 for DIV clocks, then go to DATA with bit index 0.
REQ-023 DATA: tx_out equals shift[index] for DIV clocks each; after index 7 go to STOP.
REQ-024 STOP: tx_out=1 for DIV clocks; on its last clock, if the FIFO is non-empty, pop and go directly to START (no idle gap), else go to IDLE.
REQ-025 tx_busy SHALL be 1 in START, DATA and STOP.
REQ-026 Latency: a write accepted at edge N into an empty FIFO while IDLE SHALL drive tx_out=0 from edge N+2.
REQ-027 Bytes SHALL be transmitted in write order with none lost or duplicated.
REQ-028 Changes to tx_data or tx_valid during a frame SHALL NOT alter the byte being shifted.

Reset
REQ-029 On an edge with rst_n=0, the outputs SHALL become: tx_out=1, tx_busy=0, buffer_empty=1, buffer_full=0, overflow=0; state IDLE; pointers, count, baud counter and bit index all 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame and discard all buffered bytes; no partial frame resumes after release.
REQ-031 Writes presented while rst_n=0 SHALL be ignored.

Verification
REQ-032 Single byte: write 0x41 -> line shows 0,1,0,0,0,0,0,1,0,1, each bit 434 clocks; tx_busy high exactly 4340 clocks; buffer_empty=1 after the pop.
REQ-033 Back-to-back: write "HELLO" (0x48,0x45,0x4C,0x4C,0x4F) in 5 consecutive cycles -> 5 contiguous frames, no idle between stop and next start, bytes decoded in order; a uart_rx loopback reports rx_data=0x4F last with eos_flag=0.
REQ-034 Full/overflow: with the FSM busy, write 33 bytes at default depth -> buffer_full=1 after 32 accepted (1 of the 33 may already be popped, so check count), overflow pulses exactly once per dropped write, and transmitted bytes match the accepted ones only.
REQ-035 Simultaneous write and pop: write timed to the last STOP clock with 1 byte queued -> count unchanged, order preserved.
REQ-036 Reset mid-frame: assert rst_n=0 during DATA bit 3 with 4 bytes queued -> tx_out=1 on the next edge, buffer_empty=1, and no further frames after release until a new write.
REQ-037 Latency: write 0x55 at edge N while IDLE -> tx_out=0 first at edge N+2.

Source files
------------

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a baud-timed shift FSM.
// tx_out/tx_busy follow the FSM state one clock later, so every bit holds exactly DIV clocks.
module uart_tx #(
    parameter int unsigned CLK_FREQ        = 50_000_000,
    parameter int unsigned BAUD_RATE       = 115200,
    parameter int unsigned TX_BUFFER_DEPTH = 32
) (
    input  logic       clk_50mhz,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_out,
    output logic       tx_busy,
    output logic       buffer_full,
    output logic       buffer_empty,
    output logic       overflow
);

    localparam int unsigned DIV    = CLK_FREQ / BAUD_RATE;
    localparam int unsigned BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned PTR_W  = $clog2(TX_BUFFER_DEPTH);
    localparam int unsigned CNT_W  = $clog2(TX_BUFFER_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t            state;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;

    logic [7:0]        mem [TX_BUFFER_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_next;

    logic              wr_en_c;
    logic              pop_c;
    logic              baud_last_c;

    // Full is the registered flag, so a write while full is dropped even if a pop happens this cycle.
    always_comb begin
        wr_en_c     = tx_valid && !buffer_full;
        baud_last_c = (baud_cnt == BAUD_W'(DIV - 1));
        pop_c       = (count != '0) &&
                      ((state == IDLE) || ((state == STOP) && baud_last_c));
        count_next  = count;
        if (wr_en_c && !pop_c) begin
            count_next = count + CNT_W'(1);
        end else if (!wr_en_c && pop_c) begin
            count_next = count - CNT_W'(1);
        end
    end

    // FIFO storage carries no reset; writes are blocked while in reset.
    always_ff @(posedge clk_50mhz) begin
        if (rst_n && wr_en_c) begin
            mem[wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            buffer_empty <= 1'b1;
            buffer_full  <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            if (wr_en_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count        <= count_next;
            buffer_empty <= (count_next == '0);
            buffer_full  <= (count_next == CNT_W'(TX_BUFFER_DEPTH));
            overflow     <= tx_valid && buffer_full;
        end
    end

    // Frame FSM; line outputs are registered from the current state.
    always_ff @(posedge clk_50mhz) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            tx_out   <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE:    begin tx_out <= 1'b1;           tx_busy <= 1'b0; end
                START:   begin tx_out <= 1'b0;           tx_busy <= 1'b1; end
                DATA:    begin tx_out <= shift[bit_idx]; tx_busy <= 1'b1; end
                default: begin tx_out <= 1'b1;           tx_busy <= 1'b1; end
            endcase

            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    if (pop_c) begin
                        shift <= mem[rd_ptr];
                        state <= START;
                    end
                end
                START: begin
                    if (baud_last_c) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_last_c) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
                default: begin
                    if (baud_last_c) begin
                        baud_cnt <= '0;
                        if (pop_c) begin
                            shift <= mem[rd_ptr];
                            state <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: writers push expected bytes, a line monitor decodes frames and pops.
// Uses a small bit period (DIV=10) so long sequences stay short.
module tb_uart_tx;

    localparam int unsigned CLK_FREQ  = 1000;
    localparam int unsigned BAUD_RATE = 100;
    localparam int unsigned DEPTH     = 32;
    localparam int unsigned DIV       = CLK_FREQ / BAUD_RATE;
    localparam int unsigned FRAME     = 10 * DIV;

    logic       clk_50mhz = 1'b0;
    logic       rst_n     = 1'b0;
    logic [7:0] tx_data   = 8'h00;
    logic       tx_valid  = 1'b0;
    logic       tx_out;
    logic       tx_busy;
    logic       buffer_full;
    logic       buffer_empty;
    logic       overflow;

    uart_tx #(
        .CLK_FREQ       (CLK_FREQ),
        .BAUD_RATE      (BAUD_RATE),
        .TX_BUFFER_DEPTH(DEPTH)
    ) dut (
        .clk_50mhz   (clk_50mhz),
        .rst_n       (rst_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_out      (tx_out),
        .tx_busy     (tx_busy),
        .buffer_full (buffer_full),
        .buffer_empty(buffer_empty),
        .overflow    (overflow)
    );

    always #5 clk_50mhz = ~clk_50mhz;

    int cyc = 0;
    always @(posedge clk_50mhz) cyc <= cyc + 1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    logic [7:0] exp_q[$];
    int         starts[$];
    int         busy_cnt = 0;
    int         ovf_cnt  = 0;
    int         last_wr_cyc = 0;

    always @(negedge clk_50mhz) begin
        if (tx_busy)  busy_cnt++;
        if (overflow) ovf_cnt++;
    end

    // Line monitor: checks both the first and last clock of every bit, then scores the byte.
    bit         mon_active = 1'b0;
    bit         mon_err;
    int         mon_cnt, mb, moff;
    logic [7:0] mon_byte;

    always @(negedge clk_50mhz) begin
        if (!rst_n) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && tx_out === 1'b0) begin
                mon_active = 1'b1;
                mon_cnt    = 0;
                mon_err    = 1'b0;
                mon_byte   = 8'h00;
                starts.push_back(cyc);
            end
            if (mon_active) begin
                mb   = mon_cnt / DIV;
                moff = mon_cnt % DIV;
                if (moff == 0 || moff == DIV - 1) begin
                    if (mb == 0) begin
                        if (tx_out !== 1'b0) mon_err = 1'b1;
                    end else if (mb == 9) begin
                        if (tx_out !== 1'b1) mon_err = 1'b1;
                    end else if (moff == 0) begin
                        mon_byte[3'(mb - 1)] = tx_out;
                    end else if (tx_out !== mon_byte[3'(mb - 1)]) begin
                        mon_err = 1'b1;
                    end
                end
                mon_cnt++;
                if (mon_cnt == FRAME) begin
                    mon_active = 1'b0;
                    check("frame_format", 32'(mon_err), 32'd0);
                    check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
                    if (exp_q.size() != 0) check("frame_byte", 32'(mon_byte), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_50mhz);
    endtask

    // Called at a falling edge; the strobe is sampled on the following rising edge.
    task automatic write_byte(input logic [7:0] d, input bit accept);
        tx_data  = d;
        tx_valid = 1'b1;
        @(negedge clk_50mhz);
        tx_valid    = 1'b0;
        last_wr_cyc = cyc;
        if (accept) exp_q.push_back(d);
    endtask

    task automatic wait_start(input int n);
        int t = 0;
        while (starts.size() <= n && t < 3 * FRAME) begin
            @(negedge clk_50mhz);
            t++;
        end
        check("start_seen", 32'(starts.size() > n), 32'd1);
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk_50mhz);
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((exp_q.size() != 0 || tx_busy || mon_active) && t < 50 * FRAME) begin
            @(negedge clk_50mhz);
            t++;
        end
        check(name, 32'(t < 50 * FRAME), 32'd1);
        tick(3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [7:0] hello [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};
    int n, n2, s;

    initial begin
        // Reset, with a write strobe that must be ignored
        tx_valid = 1'b1;
        tx_data  = 8'hA5;
        tick(3);
        tx_valid = 1'b0;
        check("rst_tx_out", 32'(tx_out), 32'd1);
        check("rst_busy", 32'(tx_busy), 32'd0);
        check("rst_empty", 32'(buffer_empty), 32'd1);
        check("rst_full", 32'(buffer_full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        tick(5);
        check("post_rst_idle", 32'(starts.size()), 32'd0);

        // Latency: start bit first visible two edges after the accepting edge
        n = starts.size();
        write_byte(8'h55, 1'b1);
        wait_start(n);
        if (starts.size() > n) check("latency", 32'(starts[n] - last_wr_cyc), 32'd2);
        wait_drain("latency_drain");

        // Single byte: busy duration and empty after the pop
        busy_cnt = 0;
        n = starts.size();
        write_byte(8'h41, 1'b1);
        wait_start(n);
        check("empty_after_pop", 32'(buffer_empty), 32'd1);
        wait_drain("single_drain");
        check("busy_cycles", 32'(busy_cnt), 32'(FRAME));

        // Back-to-back "HELLO": contiguous frames, in order
        n = starts.size();
        foreach (hello[i]) write_byte(hello[i], 1'b1);
        wait_drain("hello_drain");
        check("hello_frames", 32'(starts.size() - n), 32'd5);
        for (int i = 1; i < 5; i++)
            if (starts.size() > n + i) check("hello_gap", 32'(starts[n + i] - starts[n + i - 1]), 32'(FRAME));

        // Overflow: 33 writes while busy, last one dropped
        n = starts.size();
        write_byte(8'hA0, 1'b1);
        wait_start(n);
        ovf_cnt = 0;
        for (int i = 0; i < 32; i++) write_byte(8'(i + 1), 1'b1);
        check("full_after_32", 32'(buffer_full), 32'd1);
        check("no_early_ovf", 32'(overflow), 32'd0);
        write_byte(8'hEE, 1'b0);
        check("ovf_pulse", 32'(overflow), 32'd1);
        tick(1);
        check("ovf_one_cycle", 32'(overflow), 32'd0);
        wait_drain("ovf_drain");
        check("ovf_count", 32'(ovf_cnt), 32'd1);
        check("ovf_empty", 32'(buffer_empty), 32'd1);

        // Write coinciding with the pop on the last stop clock
        n = starts.size();
        write_byte(8'h11, 1'b1);
        wait_start(n);
        s = (starts.size() > n) ? starts[n] : cyc;
        write_byte(8'h22, 1'b1);
        wait_until(s - 2 + FRAME);
        write_byte(8'h33, 1'b1);
        check("simul_not_empty", 32'(buffer_empty), 32'd0);
        check("simul_not_full", 32'(buffer_full), 32'd0);
        wait_drain("simul_drain");
        check("simul_frames", 32'(starts.size() - n), 32'd3);
        if (starts.size() >= n + 3) begin
            check("simul_gap1", 32'(starts[n + 1] - starts[n]), 32'(FRAME));
            check("simul_gap2", 32'(starts[n + 2] - starts[n + 1]), 32'(FRAME));
        end

        // Reset during data bit 3 with four bytes queued
        n = starts.size();
        write_byte(8'h5A, 1'b1);
        wait_start(n);
        s = (starts.size() > n) ? starts[n] : cyc;
        for (int i = 0; i < 4; i++) write_byte(8'hC1 + 8'(i), 1'b1);
        wait_until(s + 4 * DIV + 3);
        rst_n    = 1'b0;
        tx_valid = 1'b1;
        tx_data  = 8'h99;
        tick(1);
        check("midrst_tx_out", 32'(tx_out), 32'd1);
        check("midrst_empty", 32'(buffer_empty), 32'd1);
        check("midrst_busy", 32'(tx_busy), 32'd0);
        exp_q.delete();
        tick(1);
        rst_n    = 1'b1;
        tx_valid = 1'b0;
        n2 = starts.size();
        tick(3 * FRAME);
        check("midrst_no_frames", 32'(starts.size() - n2), 32'd0);
        check("midrst_still_empty", 32'(buffer_empty), 32'd1);
        write_byte(8'h3C, 1'b1);
        wait_drain("post_rst_drain");
        check("post_rst_frames", 32'(starts.size() - n2), 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
